// File: rtl/stack_ctrl_pkg.sv
// Shared definitions for the stack sequencer and the core's stack-op decoder:
// command encodings, default RAM depth and controller state encoding.
package stack_ctrl_pkg;

  // Default number of 32-bit stack entries (power of two, at least 4)
  localparam int RAM_DEPTH = 16;

  // Width of stack entries and of the RAM address/data buses
  localparam int DATA_W = 32;

  // Stack command encodings driven on cmd_op by the core decoder
  typedef enum logic [1:0] {
    STK_NOP  = 2'b00,
    STK_PUSH = 2'b01,
    STK_POP  = 2'b10,
    STK_REPL = 2'b11
  } stk_op_e;

  // Controller states: IDLE accepts commands, FETCH waits for the NOS refill
  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_FETCH = 1'b1
  } stk_state_e;

  // err_cause bit positions
  localparam int CAUSE_OVF = 0;
  localparam int CAUSE_UDF = 1;

endpackage

// File: rtl/stack_ctrl.sv
// stack_ctrl: sequencer for the stack RAM (port A read/write, port B
// registered read-only). Keeps the depth counter and caches TOS/NOS in
// registers so both operands are available with zero read latency.
// Optional feature macro: STACK_BOUNDS_EN enables the sticky overflow /
// underflow error flags; without it err and err_cause are tied to 0.
module stack_ctrl
  import stack_ctrl_pkg::*;
#(
  parameter int DEPTH = RAM_DEPTH,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [DATA_W-1:0] cmd_data,
  output logic [DATA_W-1:0] tos,
  output logic [DATA_W-1:0] nos,
  output logic [AW:0]       count,
  output logic              full,
  output logic              empty,
  output logic              err,
  output logic [1:0]        err_cause,
  output logic [DATA_W-1:0] ram_addr_a,
  output logic [DATA_W-1:0] ram_datain_a,
  output logic              ram_wr_a,
  input  logic [DATA_W-1:0] ram_data_a,
  output logic [DATA_W-1:0] ram_addr_b,
  input  logic [DATA_W-1:0] ram_data_b
);

  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);
  localparam logic [AW:0] ONE_C   = (AW+1)'(1);
  localparam logic [AW:0] TWO_C   = (AW+1)'(2);
  localparam logic [AW:0] THREE_C = (AW+1)'(3);

  stk_state_e        state;
  stk_state_e        state_nxt;

  logic [AW:0]       count_r;
  logic [DATA_W-1:0] tos_r;
  logic [DATA_W-1:0] nos_r;

  logic              accept;
  logic              is_push;
  logic              is_pop;
  logic              is_repl;
  logic              full_i;
  logic              empty_i;
  logic              do_push;
  logic              do_pop;
  logic              do_repl;
  logic              ovf;
  logic              udf;
  logic              need_fetch;
  logic [AW:0]       cnt_dec;
  logic [AW:0]       cnt_m2;
  logic [AW:0]       cnt_m3;
  logic [AW-1:0]     addr_a;
  logic [AW-1:0]     addr_b;

  // Command decode; out-of-bounds commands are accepted but have no effect
  assign accept  = cmd_valid && (state == ST_IDLE);
  assign is_push = accept && (cmd_op == STK_PUSH);
  assign is_pop  = accept && (cmd_op == STK_POP);
  assign is_repl = accept && (cmd_op == STK_REPL);

  assign full_i  = (count_r == DEPTH_C);
  assign empty_i = (count_r == '0);

  assign do_push = is_push && !full_i;
  assign do_pop  = is_pop  && !empty_i;
  assign do_repl = is_repl && !empty_i;
  assign ovf     = is_push && full_i;
  assign udf     = (is_pop || is_repl) && empty_i;

  assign cnt_dec = count_r - ONE_C;
  assign cnt_m2  = count_r - TWO_C;
  assign cnt_m3  = count_r - THREE_C;

  // A POP that leaves two or more entries must refill NOS from RAM
  assign need_fetch = do_pop && (cnt_dec >= TWO_C);

  // Next-state logic for the IDLE/FETCH sequencer
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (need_fetch) state_nxt = ST_FETCH;
      ST_FETCH: state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // Port A: write on in-bounds PUSH/REPL, otherwise park on the TOS address
  always_comb begin
    addr_a       = cnt_dec[AW-1:0];
    ram_datain_a = '0;
    ram_wr_a     = 1'b0;
    if (do_push) begin
      addr_a       = count_r[AW-1:0];
      ram_datain_a = cmd_data;
      ram_wr_a     = 1'b1;
    end else if (do_repl) begin
      addr_a       = cnt_dec[AW-1:0];
      ram_datain_a = cmd_data;
      ram_wr_a     = 1'b1;
    end
  end

  // Port B: during a refilling POP read the new NOS (old count-3), otherwise
  // point at the current NOS so the read port is never left floating
  always_comb begin
    addr_b = cnt_m2[AW-1:0];
    if (need_fetch) addr_b = cnt_m3[AW-1:0];
  end

  assign ram_addr_a = {{(DATA_W-AW){1'b0}}, addr_a};
  assign ram_addr_b = {{(DATA_W-AW){1'b0}}, addr_b};

  // Depth counter and TOS/NOS cache; the FETCH cycle captures the RAM read
  always_ff @(posedge clk) begin
    if (rst) begin
      count_r <= '0;
      tos_r   <= '0;
      nos_r   <= '0;
    end else if (state == ST_FETCH) begin
      nos_r <= ram_data_b;
    end else if (do_push) begin
      count_r <= count_r + ONE_C;
      tos_r   <= cmd_data;
      nos_r   <= tos_r;
    end else if (do_repl) begin
      tos_r <= cmd_data;
    end else if (do_pop) begin
      count_r <= cnt_dec;
      tos_r   <= (cnt_dec == '0) ? '0 : nos_r;
      if (cnt_dec < TWO_C) nos_r <= '0;
    end
  end

`ifdef STACK_BOUNDS_EN
  logic [1:0] cause_r;
  logic       unused_ok;

  // Sticky error causes, cleared only by reset
  always_ff @(posedge clk) begin
    if (rst) begin
      cause_r <= 2'b00;
    end else begin
      if (ovf) cause_r[CAUSE_OVF] <= 1'b1;
      if (udf) cause_r[CAUSE_UDF] <= 1'b1;
    end
  end

  assign err_cause = cause_r;
  assign err       = |cause_r;
  assign unused_ok = ^ram_data_a;
`else
  logic unused_ok;

  assign err_cause = 2'b00;
  assign err       = 1'b0;
  assign unused_ok = ^{ram_data_a, ovf, udf};
`endif

  assign cmd_ready = (state == ST_IDLE);
  assign tos       = tos_r;
  assign nos       = nos_r;
  assign count     = count_r;
  assign full      = full_i;
  assign empty     = empty_i;

endmodule
